clock_display_core: RTL and testbench
=====================================

# clock_display_core

Digital-clock datapath: keeps hours/minutes/seconds in BCD, converts the selected digit to a 7-segment pattern, and serialises each digit as an 8-bit frame for an external LED shift-register chain. It sits between the 1 Hz tick generator / set buttons and the display driver pins. It comprises the time counter, the BCD-to-segment digit multiplexer and the parallel-load digit shift register, all in one clock domain.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low freezes all state; `serial_out`=0.
- `tick`  in  1  one-cycle strobe, advances time by one second.
- `military_time`  in  1  1 = 24 h display, 0 = 12 h display.
- `set_hours`  in  1  one-cycle strobe, increments hours.
- `set_minutes`  in  1  one-cycle strobe, increments minutes.
- `pm`  out  1  internal hour ≥ 12 (valid in both modes).
- `hours_msd`, `hours_lsd`, `minutes_msd`, `minutes_lsd`, `seconds_msd`, `seconds_lsd`  out  4 each  displayed BCD digits.
- `digit_sel`  out  3  digit currently being serialised, 0..5.
- `serial_out`  out  1  serial segment data, MSB first.
- `latch`  out  1  high during the last bit of each frame.

## Operation
- Time state: seconds 0..59, minutes 0..59, hours 0..23 (internal). Reset value is 00:00:00 (12 h mode: 12:00:00, `pm`=0).
- Time counting on `tick` with `en`=1:
  - Seconds increment.
  - 59→00 carries to minutes.
  - Minutes 59→00 carries to hours.
  - Hours 23→0.
- `set_minutes`: minutes +1 with wrap 59→0. No carry to hours. Seconds unchanged.
- `set_hours`: hours +1 with wrap 23→0.
- If a set strobe and `tick` occur in the same cycle, the set is applied and the tick is dropped. Both set strobes together apply both.
- Display mapping:
  - 24 h: hours shown 00..23.
  - 12 h: internal 0→12, 1..12→1..12, 13..23→1..11.
  - BCD outputs are combinational from state.
- Digit mux: `digit_sel` 0..5 selects, in order, hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd.
- Segment code: bit6=a, 5=b, 4=c, 3=d, 2=e, 1=f, 0=g, active high, standard patterns:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex).
  - Codes 10..15 are blank (00).
  - Segment output is 00 when `en`=0.
- Decimal point (frame bit 7):
  - Set on digits 1 and 3 (separators).
  - Set on digit 5 when `military_time`=0 and `pm`=1.
  - Clear otherwise.
- Frame: 8 bits, {dp, a, b, c, d, e, f, g}, shifted MSB first.

## Timing
- `frame_cnt` counts 0..8, then wraps to 0. Reset value 0. It advances only when `en`=1.
- Edge ending count 0: the shift register is parallel-loaded with the frame for the current `digit_sel`.
- Edges ending counts 1..7: shift left by one, filling with 0.
- `serial_out` = shift-register bit 7, registered. Frame bit 7 is on the wire at count 1 and bit 0 at count 8.
- `latch` = 1 exactly while `frame_cnt`=8.
- At the edge ending count 8, `digit_sel` advances, wrapping 5→0.
- A full scan takes 54 cycles.
- Reset values: `digit_sel`=0, shift register 00, `serial_out`=0, `latch`=0, time 00:00:00.
- Time changes mid-frame do not affect the frame already loaded.
- Reset asserted mid-frame clears everything immediately. After release, the first frame loads at count 0.
- `en` low: all counters and registers hold their values; strobes are ignored (not queued).

## Structure
- Shared package: segment code constants for digits 0..9 and blank, the digit index constants 0..5, and frame length 8 and frame period 9.
- Sub-modules:
  - `time_counter`: BCD time state plus the 12/24 h mapping.
  - `segment_encoder`: combinational BCD→7-segment conversion.
- The frame counter, mux and shift register live in the top level.

## Test plan
- Reset, 24 h mode, 3661 ticks → 01:01:01, `pm`=0.
- Preset via set strobes to 23:59:59, then one tick → 00:00:00. With 12 h selected, this displays 12:00:00, `pm`=0.
- 12 h mode, 13 `set_hours` strobes from reset → hours display 01, `pm`=1, digit 5 frame bit 7 = 1.
- `set_minutes` at 00:59:30 → 00:00:30, hours unchanged. `set_minutes` and `tick` in the same cycle → minutes +1, seconds unchanged.
- Time 00:00:08, sample `serial_out` for counts 1..8 at `digit_sel`=5 → bits 0,1,1,1,1,1,1,1 (8 = 7F), `latch` high only at count 8, then `digit_sel` wraps to 0.
- `en`=0 for 20 cycles with ticks applied → time, `frame_cnt` and `digit_sel` unchanged, `serial_out`=0. Assert `reset_n` mid-frame → outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/clock_display_core_pkg.sv
// Shared definitions for the digital-clock display datapath.
// Holds the seven-segment codes (bit6=a .. bit0=g, active high), the
// scan order of the six displayed digits, frame geometry, and a
// two-digit BCD increment helper used by the time counter.
package clock_display_core_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] DIG_HOURS_MSD   = 3'd0;
  localparam logic [2:0] DIG_HOURS_LSD   = 3'd1;
  localparam logic [2:0] DIG_MINUTES_MSD = 3'd2;
  localparam logic [2:0] DIG_MINUTES_LSD = 3'd3;
  localparam logic [2:0] DIG_SECONDS_MSD = 3'd4;
  localparam logic [2:0] DIG_SECONDS_LSD = 3'd5;

  localparam int unsigned FRAME_LEN    = 8;
  localparam int unsigned FRAME_PERIOD = 9;
  // Count value during which the last frame bit is on the wire.
  localparam logic [3:0]  FRAME_LAST   = 4'(FRAME_PERIOD - 1);
  // Last count at whose ending edge the shift register still shifts.
  localparam logic [3:0]  SHIFT_LAST   = 4'(FRAME_LEN - 1);

  // Increment a two-digit BCD value, wrapping to 00 after 'last'.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_display_core_segment_encoder.sv
// Combinational BCD digit to seven-segment pattern.
// Ports: bcd (4-bit digit in), seg (7-bit pattern out, a..g, blank for 10..15).
module segment_encoder
  import clock_display_core_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup; non-decimal codes render blank.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_core_time_counter.sv
// BCD time-of-day state (hh:mm:ss, 24 h internally) with 12/24 h display mapping.
// Ports: clk, reset_n (async active low), en (freeze when low), tick (+1 s),
// set_hours / set_minutes (increment strobes, override tick), military_time
// (1 = 24 h display), pm (internal hour >= 12), six BCD display digits.
module time_counter
  import clock_display_core_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       tick,
  input  logic       set_hours,
  input  logic       set_minutes,
  input  logic       military_time,
  output logic       pm,
  output logic [3:0] hours_msd,
  output logic [3:0] hours_lsd,
  output logic [3:0] minutes_msd,
  output logic [3:0] minutes_lsd,
  output logic [3:0] seconds_msd,
  output logic [3:0] seconds_lsd
);

  logic [7:0] sec_r;
  logic [7:0] min_r;
  logic [7:0] hour_r;
  logic [7:0] hour_disp_s;

  // Time state; a set strobe wins over a simultaneous tick, which is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_r  <= 8'h00;
      min_r  <= 8'h00;
      hour_r <= 8'h00;
    end else if (en) begin
      if (set_hours || set_minutes) begin
        if (set_hours)   hour_r <= bcd2_inc(hour_r, 8'h23);
        if (set_minutes) min_r  <= bcd2_inc(min_r, 8'h59);
      end else if (tick) begin
        sec_r <= bcd2_inc(sec_r, 8'h59);
        if (sec_r == 8'h59) begin
          min_r <= bcd2_inc(min_r, 8'h59);
          if (min_r == 8'h59) hour_r <= bcd2_inc(hour_r, 8'h23);
        end
      end
    end
  end

  // 12 h mapping done directly in BCD: 00 shows 12, 13..23 show 01..11.
  always_comb begin
    hour_disp_s = hour_r;
    if (military_time) begin
      hour_disp_s = hour_r;
    end else begin
      case (hour_r)
        8'h00:   hour_disp_s = 8'h12;
        8'h13:   hour_disp_s = 8'h01;
        8'h14:   hour_disp_s = 8'h02;
        8'h15:   hour_disp_s = 8'h03;
        8'h16:   hour_disp_s = 8'h04;
        8'h17:   hour_disp_s = 8'h05;
        8'h18:   hour_disp_s = 8'h06;
        8'h19:   hour_disp_s = 8'h07;
        8'h20:   hour_disp_s = 8'h08;
        8'h21:   hour_disp_s = 8'h09;
        8'h22:   hour_disp_s = 8'h10;
        8'h23:   hour_disp_s = 8'h11;
        default: hour_disp_s = hour_r;
      endcase
    end
  end

  // BCD ordering matches numeric ordering, so a plain compare gives pm.
  assign pm          = (hour_r >= 8'h12);
  assign hours_msd   = hour_disp_s[7:4];
  assign hours_lsd   = hour_disp_s[3:0];
  assign minutes_msd = min_r[7:4];
  assign minutes_lsd = min_r[3:0];
  assign seconds_msd = sec_r[7:4];
  assign seconds_lsd = sec_r[3:0];

endmodule

// File: rtl/clock_display_core.sv
// Digital-clock datapath top: time counter, digit mux, segment encoding and
// a parallel-load shift register that serialises one 8-bit frame
// {dp,a,b,c,d,e,f,g} per digit, MSB first, over a 9-cycle frame period.
// Ports: clk, reset_n, en, tick, military_time, set_hours, set_minutes (in);
// pm, six BCD digits, digit_sel, serial_out, latch (out).
module clock_display_core
  import clock_display_core_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       tick,
  input  logic       military_time,
  input  logic       set_hours,
  input  logic       set_minutes,
  output logic       pm,
  output logic [3:0] hours_msd,
  output logic [3:0] hours_lsd,
  output logic [3:0] minutes_msd,
  output logic [3:0] minutes_lsd,
  output logic [3:0] seconds_msd,
  output logic [3:0] seconds_lsd,
  output logic [2:0] digit_sel,
  output logic       serial_out,
  output logic       latch
);

  logic [3:0] frame_cnt_r;
  logic [3:0] frame_cnt_next_s;
  logic [2:0] digit_sel_r;
  logic [7:0] shift_r;
  logic [7:0] shift_next_s;
  logic       serial_r;
  logic       latch_r;
  logic [3:0] digit_bcd_s;
  logic [6:0] seg_raw_s;
  logic [6:0] seg_s;
  logic       dp_s;
  logic [7:0] frame_s;

  time_counter u_time (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en),
    .tick          (tick),
    .set_hours     (set_hours),
    .set_minutes   (set_minutes),
    .military_time (military_time),
    .pm            (pm),
    .hours_msd     (hours_msd),
    .hours_lsd     (hours_lsd),
    .minutes_msd   (minutes_msd),
    .minutes_lsd   (minutes_lsd),
    .seconds_msd   (seconds_msd),
    .seconds_lsd   (seconds_lsd)
  );

  // Select the digit being scanned and its decimal point.
  always_comb begin
    digit_bcd_s = 4'hF;
    dp_s        = 1'b0;
    case (digit_sel_r)
      DIG_HOURS_MSD:   digit_bcd_s = hours_msd;
      DIG_HOURS_LSD:   begin digit_bcd_s = hours_lsd;   dp_s = 1'b1; end
      DIG_MINUTES_MSD: digit_bcd_s = minutes_msd;
      DIG_MINUTES_LSD: begin digit_bcd_s = minutes_lsd; dp_s = 1'b1; end
      DIG_SECONDS_MSD: digit_bcd_s = seconds_msd;
      DIG_SECONDS_LSD: begin digit_bcd_s = seconds_lsd; dp_s = ~military_time & pm; end
      default:         begin digit_bcd_s = 4'hF;        dp_s = 1'b0; end
    endcase
  end

  segment_encoder u_seg (
    .bcd (digit_bcd_s),
    .seg (seg_raw_s)
  );

  // Frame assembly and next-state of frame counter / shift register.
  always_comb begin
    seg_s            = SEG_BLANK;
    frame_cnt_next_s = 4'd0;
    shift_next_s     = shift_r;
    if (en) begin
      seg_s = seg_raw_s;
    end else begin
      seg_s = SEG_BLANK;
    end
    frame_s = {dp_s, seg_s};
    if (frame_cnt_r == FRAME_LAST) begin
      frame_cnt_next_s = 4'd0;
    end else begin
      frame_cnt_next_s = frame_cnt_r + 4'd1;
    end
    if (frame_cnt_r == 4'd0) begin
      shift_next_s = frame_s;
    end else if (frame_cnt_r <= SHIFT_LAST) begin
      shift_next_s = {shift_r[6:0], 1'b0};
    end else begin
      shift_next_s = shift_r;
    end
  end

  // Scan state; serial_r tracks the bit the shift register will present, so
  // frame bit 7 is on the wire during count 1 and bit 0 during count 8.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= 4'd0;
      digit_sel_r <= 3'd0;
      shift_r     <= 8'h00;
      serial_r    <= 1'b0;
      latch_r     <= 1'b0;
    end else if (en) begin
      frame_cnt_r <= frame_cnt_next_s;
      shift_r     <= shift_next_s;
      serial_r    <= shift_next_s[7];
      latch_r     <= (frame_cnt_next_s == FRAME_LAST);
      if (frame_cnt_r == FRAME_LAST) begin
        digit_sel_r <= (digit_sel_r == DIG_SECONDS_LSD) ? 3'd0 : digit_sel_r + 3'd1;
      end
    end
  end

  assign serial_out = serial_r & en;
  assign latch      = latch_r;
  assign digit_sel  = digit_sel_r;

endmodule

// File: tb/tb_clock_display_core.sv
module tb_clock_display_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic       military_time = 1'b1;
  logic       set_hours = 1'b0;
  logic       set_minutes = 1'b0;
  logic       pm;
  logic [3:0] hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd;
  logic [2:0] digit_sel;
  logic       serial_out;
  logic       latch;

  clock_display_core dut (
    .clk (clk), .reset_n (reset_n), .en (en), .tick (tick),
    .military_time (military_time), .set_hours (set_hours), .set_minutes (set_minutes),
    .pm (pm), .hours_msd (hours_msd), .hours_lsd (hours_lsd),
    .minutes_msd (minutes_msd), .minutes_lsd (minutes_lsd),
    .seconds_msd (seconds_msd), .seconds_lsd (seconds_lsd),
    .digit_sel (digit_sel), .serial_out (serial_out), .latch (latch)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: time as plain integers, scan position as frame index.
  int         m_h, m_m, m_s, m_cnt, m_dsel;
  logic [7:0] m_frame;
  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  function automatic int disp_hours();
    if (military_time) return m_h;
    if (m_h == 0) return 12;
    if (m_h > 12) return m_h - 12;
    return m_h;
  endfunction

  function automatic int digit_val(int idx);
    case (idx)
      0: return disp_hours() / 10;
      1: return disp_hours() % 10;
      2: return m_m / 10;
      3: return m_m % 10;
      4: return m_s / 10;
      default: return m_s % 10;
    endcase
  endfunction

  function automatic logic [7:0] frame_of(int idx);
    logic dp;
    dp = (idx == 1) || (idx == 3) || (idx == 5 && !military_time && m_h >= 12);
    return {dp, seg_tab[digit_val(idx)]};
  endfunction

  function automatic logic exp_serial();
    if (!en) return 1'b0;
    if (m_cnt == 0) return m_frame[0];
    return m_frame[8 - m_cnt];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_dsel = 0; m_frame = 8'h00;
  endtask

  // One enabled clock edge of the reference behaviour.
  task automatic model_edge();
    int t;
    if (!en) return;
    if (m_cnt == 0) m_frame = frame_of(m_dsel);
    if (set_hours || set_minutes) begin
      if (set_hours)   m_h = (m_h + 1) % 24;
      if (set_minutes) m_m = (m_m + 1) % 60;
    end else if (tick) begin
      t = ((m_h * 60 + m_m) * 60 + m_s + 1) % 86400;
      m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
    end
    if (m_cnt == 8) m_dsel = (m_dsel + 1) % 6;
    m_cnt = (m_cnt + 1) % 9;
  endtask

  task automatic check_all();
    chk("hours_msd",   32'(hours_msd),   digit_val(0));
    chk("hours_lsd",   32'(hours_lsd),   digit_val(1));
    chk("minutes_msd", 32'(minutes_msd), digit_val(2));
    chk("minutes_lsd", 32'(minutes_lsd), digit_val(3));
    chk("seconds_msd", 32'(seconds_msd), digit_val(4));
    chk("seconds_lsd", 32'(seconds_lsd), digit_val(5));
    chk("pm",          32'(pm),          32'(m_h >= 12));
    chk("digit_sel",   32'(digit_sel),   m_dsel);
    chk("latch",       32'(latch),       32'(m_cnt == 8));
    chk("serial_out",  32'(serial_out),  32'(exp_serial()));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic strobe(input logic sh, input logic sm, input logic tk);
    set_hours = sh; set_minutes = sm; tick = tk;
    cycle();
    set_hours = 1'b0; set_minutes = 1'b0; tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    tick = 1'b0; set_hours = 1'b0; set_minutes = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  logic exp_bits [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int found;
    int snap_s, snap_m, snap_h, snap_dsel;
    model_reset();
    en = 1'b1;
    military_time = 1'b1;

    // Reset state, then 12 h rendering of midnight.
    do_reset();
    chk("rst_digit_sel", 32'(digit_sel), 32'd0);
    chk("rst_serial", 32'(serial_out), 32'd0);
    military_time = 1'b0; #1;
    chk("rst_12h_hmsd", 32'(hours_msd), 32'd1);
    chk("rst_12h_hlsd", 32'(hours_lsd), 32'd2);
    military_time = 1'b1; #1;

    // 3661 ticks in 24 h mode -> 01:01:01.
    tick = 1'b1;
    for (int i = 0; i < 3661; i++) cycle();
    tick = 1'b0;
    chk("t3661_h", 32'({hours_msd, hours_lsd}), 32'h01);
    chk("t3661_m", 32'({minutes_msd, minutes_lsd}), 32'h01);
    chk("t3661_s", 32'({seconds_msd, seconds_lsd}), 32'h01);
    chk("t3661_pm", 32'(pm), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      tick = $urandom_range(0, 1) == 1;
      set_hours = ($urandom_range(0, 11) == 0);
      set_minutes = ($urandom_range(0, 11) == 0);
      if (i % 50 == 0) military_time = $urandom_range(0, 1) == 1;
      cycle();
    end
    en = 1'b1; tick = 1'b0; set_hours = 1'b0; set_minutes = 1'b0; military_time = 1'b1;

    // Preset to 23:59:59, then roll over.
    for (int i = 0; i < 30 && m_h != 23; i++) strobe(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70 && m_m != 59; i++) strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 70 && m_s != 59; i++) strobe(1'b0, 1'b0, 1'b1);
    chk("preset_h", 32'({hours_msd, hours_lsd}), 32'h23);
    chk("preset_m", 32'({minutes_msd, minutes_lsd}), 32'h59);
    chk("preset_s", 32'({seconds_msd, seconds_lsd}), 32'h59);
    strobe(1'b0, 1'b0, 1'b1);
    chk("roll_h", 32'({hours_msd, hours_lsd}), 32'h00);
    chk("roll_ms", 32'({minutes_msd, minutes_lsd, seconds_msd, seconds_lsd}), 32'h0000);
    military_time = 1'b0; #1;
    chk("roll_12h_h", 32'({hours_msd, hours_lsd}), 32'h12);
    chk("roll_12h_pm", 32'(pm), 32'd0);

    // 12 h mode, 13 hour strobes -> 01 PM, dp lit on digit 5.
    do_reset();
    for (int i = 0; i < 13; i++) strobe(1'b1, 1'b0, 1'b0);
    chk("pm13_h", 32'({hours_msd, hours_lsd}), 32'h01);
    chk("pm13_pm", 32'(pm), 32'd1);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (m_dsel == 5 && m_cnt == 1) found = 1;
      else cycle();
    end
    chk("pm13_wait", found, 32'd1);
    chk("pm13_dp", 32'(serial_out), 32'd1);
    military_time = 1'b1;

    // set_minutes at 00:59:30, then set_minutes with tick.
    do_reset();
    for (int i = 0; i < 59; i++) strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) strobe(1'b0, 1'b0, 1'b1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("setm_wrap", 32'({hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd}), 32'h000030);
    strobe(1'b0, 1'b1, 1'b1);
    chk("setm_tick", 32'({hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd}), 32'h000130);

    // 00:00:08: serialised frame of digit 5 is 0x7F with dp clear.
    do_reset();
    for (int i = 0; i < 8; i++) strobe(1'b0, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (m_dsel == 5 && m_cnt == 0) found = 1;
      else cycle();
    end
    chk("frame8_wait", found, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk($sformatf("frame8_bit%0d", k), 32'(serial_out), 32'(exp_bits[k-1]));
      chk($sformatf("frame8_latch%0d", k), 32'(latch), 32'(k == 8));
    end
    cycle();
    chk("frame8_wrap", 32'(digit_sel), 32'd0);

    // en low for 20 cycles with strobes: everything frozen, serial_out low.
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 1'b1);
    snap_s = m_s; snap_m = m_m; snap_h = m_h; snap_dsel = m_dsel;
    en = 1'b0;
    for (int i = 0; i < 20; i++) strobe(i[0], i[1], 1'b1);
    chk("hold_s", 32'(seconds_msd * 10 + seconds_lsd), snap_s);
    chk("hold_m", 32'(minutes_msd * 10 + minutes_lsd), snap_m);
    chk("hold_h", 32'(hours_msd * 10 + hours_lsd), snap_h);
    chk("hold_dsel", 32'(digit_sel), snap_dsel);
    chk("hold_serial", 32'(serial_out), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 30; i++) strobe(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame.
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (m_dsel == 2 && m_cnt == 4) found = 1;
      else strobe(1'b0, 1'b0, 1'b1);
    end
    chk("midrst_wait", found, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_dsel", 32'(digit_sel), 32'd0);
    chk("midrst_serial", 32'(serial_out), 32'd0);
    chk("midrst_latch", 32'(latch), 32'd0);
    chk("midrst_time", 32'({hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd}), 32'h000000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
